pattern_shifter: RTL
====================

# pattern_shifter

Pattern data consumer for the blitter datapath. Takes the 8-bit byte held in the pattern data register (`PATD_0..PATD_7`, loaded from the internal data bus by `LDPATL`) and serialises it into pixels at 1, 4 or 8 bits per pixel. Requests new pattern bytes from the blitter sequencer and delivers pixels over a valid/ready handshake to the destination write path. Runs for a programmed pixel count, then signals completion.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- none; all widths fixed.

Ports:
- `MasterClock`  in  1  system clock; all state updates on its rising edge.
- `RESETL`  in  1  asynchronous active-low reset.
- `PATD`  in  8  pattern byte, driven from the pattern data register outputs `PATD_0..PATD_7`.
- `PATVALID`  in  1  one-cycle pulse: `PATD` holds the byte answering the current request.
- `PATREQ`  out  1  request for the next pattern byte.
- `START`  in  1  one-cycle pulse that begins a run.
- `MODE`  in  2  pixel depth: 00 = 1bpp, 01 = 4bpp, 10 and 11 = 8bpp.
- `LEN`  in  8  pixels in the run; 0 means 256.
- `PIXVLD`  out  1  `PIXD` holds a valid pixel.
- `PIXRDY`  in  1  consumer accepts the pixel.
- `PIXD`  out  8  pixel value, zero-extended.
- `BUSY`  out  1  run in progress.
- `DONE`  out  1  one-cycle pulse after the last pixel is accepted.

## Operation
- States: IDLE, FETCH, RUN.
- **IDLE**
  - Outputs low.
  - `START` latches `MODE` and `LEN` into internal registers, then enters FETCH.
- **FETCH**
  - `PATREQ` is high.
  - On `PATVALID`: `PATD` loads into the shift register, `PATREQ` drops and the state goes to RUN.
- **RUN**
  - `PIXVLD` is high while the shift register holds pixels.
  - A pixel transfers on `PIXVLD & PIXRDY`.
  - After each transfer the shift register advances and the remaining-pixel counter decrements.
- Pixel order, MSB first:
  - 1bpp: 8 pixels per byte, bit 7 first; `PIXD = {7'b0, bit}`.
  - 4bpp: 2 pixels per byte, high nibble first; `PIXD = {4'b0, nibble}`.
  - 8bpp: 1 pixel per byte, the whole byte.
- Per-byte pixel counter: 8, 2 or 1 pixels.
  - When the counter empties and run pixels remain, the next byte is needed: without prefetch the block returns to FETCH; with prefetch see Configuration.
- Last pixel accepted:
  - `DONE` pulses and the block returns to IDLE.
  - Any partially consumed byte is discarded.
- `START` while `BUSY` is ignored.
- `PATVALID` while `PATREQ` is low is ignored.
- `MODE` and `LEN` are sampled only at `START`; changes mid-run have no effect.
- The remaining-pixel counter is 9 bits, loaded with `LEN == 0 ? 256 : LEN`.

## Timing
- Reset values: `PATREQ`, `PIXVLD`, `BUSY`, `DONE` = 0; `PIXD` = 0; state IDLE; counters 0.
- Reset asserted mid-run aborts immediately. No `DONE` pulse is produced.
- `START` at edge n: `BUSY` and `PATREQ` are high from n+1.
- `PATVALID` at edge m: `PIXVLD` is high and `PIXD` valid from m+1.
- `PATREQ` stays high until a `PATVALID` is sampled; it drops in the cycle after.
- While `PIXVLD & !PIXRDY`, `PIXD` holds stable.
- Throughput in RUN is one pixel per cycle when `PIXRDY` is held high.
- `DONE` is asserted for one cycle, the cycle after the final transfer. `BUSY` falls in that same cycle.

## Configuration
- `PATSHIFT_PREFETCH_EN` defined:
  - Adds a one-byte holding register.
  - `PATREQ` is raised as soon as the holding register is empty and run pixels remain beyond those already buffered.
  - On byte exhaustion the holding byte moves into the shift register in the same cycle as the last transfer, so there are zero bubbles between bytes.
  - At most one byte beyond the run end is fetched.
- Undefined:
  - No holding register; the block enters FETCH only after the shift register empties.
  - Minimum gap between bytes is 2 cycles plus the sequencer's `PATVALID` latency.

## Test plan
- Reset: `RESETL` low during RUN → all outputs 0 next cycle, state IDLE, no `DONE`.
- 1bpp: `MODE`=00, `LEN`=8, byte 0xA5, `PIXRDY` high → `PIXD` = 1,0,1,0,0,1,0,1 on consecutive cycles, then `DONE`.
- 4bpp across bytes: `MODE`=01, `LEN`=3, bytes 0x3C then 0x7E → `PIXD` = 0x03, 0x0C, 0x07. Exactly two `PATREQ` handshakes; the low nibble of 0x7E is discarded.
- 8bpp with backpressure: `MODE`=10, `LEN`=2, bytes 0x81, 0xFF, `PIXRDY` low for 3 cycles → `PIXD` holds 0x81 stable for those cycles, then 0xFF, then `DONE`.
- Length zero: `MODE`=10, `LEN`=0 → exactly 256 pixels, 256 `PATREQ` handshakes. With `PATSHIFT_PREFETCH_EN`, no idle cycle between pixels when `PATVALID` is returned immediately.
- Ignored inputs: `START` pulsed mid-run and `PATVALID` with `PATREQ` low → no state or counter change.

Source files
------------

// File: rtl/pattern_shifter_if.sv
// pattern_shifter_if: pattern-request and pixel-delivery signals of pattern_shifter.
interface pattern_shifter_if;
  logic [7:0] PATD;
  logic       PATVALID;
  logic       PATREQ;
  logic       START;
  logic [1:0] MODE;
  logic [7:0] LEN;
  logic       PIXVLD;
  logic       PIXRDY;
  logic [7:0] PIXD;
  logic       BUSY;
  logic       DONE;
  modport master (
    output PATD, PATVALID, START, MODE, LEN, PIXRDY,
    input  PATREQ, PIXVLD, PIXD, BUSY, DONE
  );
  modport slave (
    input  PATD, PATVALID, START, MODE, LEN, PIXRDY,
    output PATREQ, PIXVLD, PIXD, BUSY, DONE
  );
endinterface

// File: rtl/pattern_shifter.sv
// pattern_shifter: serialises pattern bytes into 1/4/8 bpp pixels for a programmed run.
// Define PATSHIFT_PREFETCH_EN to add a one-byte holding register for bubble-free byte changes.
module pattern_shifter (
  input  logic              MasterClock,
  input  logic              RESETL,
  pattern_shifter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;
  state_t      state, state_nx;
  logic [1:0]  mode;
  logic [8:0]  rem;
  logic [7:0]  sh;
  logic [3:0]  cnt;
  logic        done;
  logic [3:0]  ppb;
  logic        xfer, take, last, empty, nxt_ok;
  logic [7:0]  sh_adv, nxt_byte;
  assign ppb    = mode == 2'b00 ? 4'd8 : mode == 2'b01 ? 4'd2 : 4'd1;
  assign xfer   = bus.PIXVLD & bus.PIXRDY;
  assign take   = bus.PATVALID & bus.PATREQ;
  assign last   = xfer && rem == 9'd1;
  assign empty  = xfer && cnt == 4'd1;
  assign sh_adv = mode == 2'b00 ? {sh[6:0], 1'b0} : mode == 2'b01 ? {sh[3:0], 4'b0} : 8'h00;
`ifdef PATSHIFT_PREFETCH_EN
  logic [7:0] hold;
  logic       hv;
  // Only request while the run still needs pixels beyond the current shift byte.
  assign bus.PATREQ = state == FETCH || (state == RUN && !hv && rem > {5'b0, cnt});
  assign nxt_ok     = hv | take;
  assign nxt_byte   = hv ? hold : bus.PATD;
  always_ff @(posedge MasterClock or negedge RESETL)
    if (!RESETL) begin
      hold <= 8'h00;
      hv   <= 1'b0;
    end else if (state != RUN || last || (empty && hv)) begin
      hv   <= 1'b0;
    end else if (take && !empty) begin
      hold <= bus.PATD;
      hv   <= 1'b1;
    end
`else
  assign bus.PATREQ = state == FETCH;
  assign nxt_ok     = 1'b0;
  assign nxt_byte   = bus.PATD;
`endif
  assign bus.PIXVLD = state == RUN;
  assign bus.PIXD   = state != RUN ? 8'h00 : mode == 2'b00 ? {7'b0, sh[7]} :
                      mode == 2'b01 ? {4'b0, sh[7:4]} : sh;
  assign bus.BUSY   = state != IDLE;
  assign bus.DONE   = done;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = bus.START ? FETCH : IDLE;
      FETCH:   state_nx = take ? RUN : FETCH;
      RUN:     state_nx = last ? IDLE : (empty && !nxt_ok) ? FETCH : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge MasterClock or negedge RESETL)
    if (!RESETL) begin
      state <= IDLE;
      mode  <= 2'b00;
      rem   <= 9'd0;
      sh    <= 8'h00;
      cnt   <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last;
      if (state == IDLE && bus.START) begin
        mode <= bus.MODE;
        rem  <= bus.LEN == 8'd0 ? 9'd256 : {1'b0, bus.LEN};
      end
      if (state == FETCH && take) begin
        sh  <= bus.PATD;
        cnt <= ppb;
      end
      if (xfer) begin
        rem <= rem - 9'd1;
        sh  <= empty && nxt_ok && !last ? nxt_byte : sh_adv;
        cnt <= empty && nxt_ok && !last ? ppb : cnt - 4'd1;
      end
    end
endmodule
